// File: rtl/line_pixel_mixer_pkg.sv
// Shared widths, RGB444 field helpers and sync-polarity helpers for the pixel mixer.
package line_pixel_mixer_pkg;

  localparam int unsigned NUM_EDGES = 6;
  localparam int unsigned COLOR_W   = 12;
  localparam int unsigned CHAN_W    = 4;
  localparam int unsigned IDX_W     = 3;

  localparam logic [COLOR_W-1:0] PAL_RESET = 12'hFFF;

  function automatic logic [CHAN_W-1:0] rgb_r(input logic [COLOR_W-1:0] c);
    return c[11:8];
  endfunction

  function automatic logic [CHAN_W-1:0] rgb_g(input logic [COLOR_W-1:0] c);
    return c[7:4];
  endfunction

  function automatic logic [CHAN_W-1:0] rgb_b(input logic [COLOR_W-1:0] c);
    return c[3:0];
  endfunction

  // Idle level of a sync line: high when the sync pulse is active low.
  function automatic logic sync_inactive(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// WIDTH-by-DEPTH shift register with a per-bit asynchronous reset value.
module sync_delay_line #(
  parameter int unsigned     WIDTH   = 1,
  parameter int unsigned     DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/line_pixel_mixer.sv
// Aligns VGA sync with the six edge-hit flags, resolves edge colour with palette and
// blinking highlight, and drives registered RGB/sync pins with frame-aligned palette commits.
module line_pixel_mixer
  import line_pixel_mixer_pkg::*;
#(
  parameter int unsigned        LINE_LAT        = 2,
  parameter int unsigned        BLINK_FRAMES    = 30,
  parameter logic [COLOR_W-1:0] BG_COLOR        = 12'h000,
  parameter logic [COLOR_W-1:0] HL_COLOR        = 12'hF00,
  parameter bit                 SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               video_on_in,
  input  logic               onLine1,
  input  logic               onLine2,
  input  logic               onLine3,
  input  logic               onLine4,
  input  logic               onLine5,
  input  logic               onLine6,
  input  logic               pal_wr_en,
  input  logic [IDX_W-1:0]   pal_wr_addr,
  input  logic [COLOR_W-1:0] pal_wr_data,
  input  logic               pal_commit,
  output logic               pal_pending,
  output logic               pal_done,
  input  logic               hl_en,
  input  logic [IDX_W-1:0]   hl_sel,
  output logic [CHAN_W-1:0]  vga_r,
  output logic [CHAN_W-1:0]  vga_g,
  output logic [CHAN_W-1:0]  vga_b,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               frame_tick
);

  localparam logic         SYNC_IDLE = sync_inactive(SYNC_ACTIVE_LOW);
  localparam int unsigned  BLINK_W   = 8;

  logic                 hs_d, vs_d, von_d;
  logic                 vs_act_q;
  logic                 boundary_c;
  logic [BLINK_W-1:0]   blink_cnt;
  logic                 blink_phase;
  logic [COLOR_W-1:0]   shadow_pal [NUM_EDGES];
  logic [COLOR_W-1:0]   active_pal [NUM_EDGES];
  logic [NUM_EDGES-1:0] on_line;
  logic                 hit_c;
  logic [IDX_W-1:0]     edge_idx_c;
  logic [COLOR_W-1:0]   pix_color_c;

  sync_delay_line #(
    .WIDTH   (3),
    .DEPTH   (LINE_LAT),
    .RST_VAL ({SYNC_IDLE, SYNC_IDLE, 1'b0})
  ) u_sync_delay (
    .clk   (CLK),
    .rst_n (rst),
    .d     ({hsync_in, vsync_in, video_on_in}),
    .q     ({hs_d, vs_d, von_d})
  );

  assign on_line    = {onLine6, onLine5, onLine4, onLine3, onLine2, onLine1};
  assign boundary_c = (vs_d != SYNC_IDLE) && !vs_act_q;

  // Lowest-numbered asserted edge wins; highlight overrides its palette colour.
  always_comb begin
    hit_c       = 1'b0;
    edge_idx_c  = '0;
    pix_color_c = BG_COLOR;
    for (int k = int'(NUM_EDGES) - 1; k >= 0; k--) begin
      if (on_line[k]) begin
        hit_c      = 1'b1;
        edge_idx_c = IDX_W'(k);
      end
    end
    if (!von_d) begin
      pix_color_c = '0;
    end else if (hit_c) begin
      if (hl_en && (hl_sel == edge_idx_c) && blink_phase) pix_color_c = HL_COLOR;
      else                                                pix_color_c = active_pal[edge_idx_c];
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      vga_r      <= '0;
      vga_g      <= '0;
      vga_b      <= '0;
      hsync_out  <= SYNC_IDLE;
      vsync_out  <= SYNC_IDLE;
      vs_act_q   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vga_r      <= rgb_r(pix_color_c);
      vga_g      <= rgb_g(pix_color_c);
      vga_b      <= rgb_b(pix_color_c);
      hsync_out  <= hs_d;
      vsync_out  <= vs_d;
      vs_act_q   <= (vs_d != SYNC_IDLE);
      frame_tick <= boundary_c;
    end
  end

  // Blink phase toggles every BLINK_FRAMES frame boundaries.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (boundary_c) begin
      if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  // Shadow takes writes any time; active copies the pre-write shadow on a pending boundary.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_EDGES); i++) begin
        shadow_pal[i] <= PAL_RESET;
        active_pal[i] <= PAL_RESET;
      end
      pal_pending <= 1'b0;
      pal_done    <= 1'b0;
    end else begin
      if (pal_wr_en && (pal_wr_addr < IDX_W'(NUM_EDGES))) shadow_pal[pal_wr_addr] <= pal_wr_data;
      pal_done <= boundary_c && pal_pending;
      if (boundary_c && pal_pending) begin
        for (int i = 0; i < int'(NUM_EDGES); i++) active_pal[i] <= shadow_pal[i];
        pal_pending <= 1'b0;
      end else if (pal_commit) begin
        pal_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_line_pixel_mixer.sv
// Directed self-checking bench for line_pixel_mixer: latency, priority, sync alignment,
// palette commit timing, boundary collisions, blink and mid-commit reset.
module tb_line_pixel_mixer;

  localparam int unsigned LL = 2;
  localparam logic [11:0] BG = 12'h0A5;
  localparam logic [11:0] HL = 12'hF00;

  logic        CLK = 1'b0;
  logic        rst;
  logic        hsync_in, vsync_in, video_on_in;
  logic        onLine1, onLine2, onLine3, onLine4, onLine5, onLine6;
  logic        pal_wr_en;
  logic [2:0]  pal_wr_addr;
  logic [11:0] pal_wr_data;
  logic        pal_commit;
  logic        pal_pending, pal_done;
  logic        hl_en;
  logic [2:0]  hl_sel;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        hsync_out, vsync_out, frame_tick;
  logic [11:0] rgb;

  int checks = 0;
  int errors = 0;
  int frames = 0;
  logic [5:0] line_pipe [LL];

  assign rgb = {vga_r, vga_g, vga_b};

  always #5 CLK = ~CLK;

  line_pixel_mixer #(
    .LINE_LAT(LL), .BLINK_FRAMES(2), .BG_COLOR(BG), .HL_COLOR(HL), .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .CLK(CLK), .rst(rst),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .video_on_in(video_on_in),
    .onLine1(onLine1), .onLine2(onLine2), .onLine3(onLine3),
    .onLine4(onLine4), .onLine5(onLine5), .onLine6(onLine6),
    .pal_wr_en(pal_wr_en), .pal_wr_addr(pal_wr_addr), .pal_wr_data(pal_wr_data),
    .pal_commit(pal_commit), .pal_pending(pal_pending), .pal_done(pal_done),
    .hl_en(hl_en), .hl_sel(hl_sel),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .frame_tick(frame_tick)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One pixel cycle; edge flags follow the counter-aligned intent by LL cycles.
  task automatic step(input logic hs, input logic vs, input logic von, input logic [5:0] lines);
    hsync_in    = hs;
    vsync_in    = vs;
    video_on_in = von;
    {onLine6, onLine5, onLine4, onLine3, onLine2, onLine1} = line_pipe[LL-1];
    for (int i = int'(LL) - 1; i > 0; i--) line_pipe[i] = line_pipe[i-1];
    line_pipe[0] = lines;
    @(posedge CLK);
    #1;
  endtask

  task automatic pix(input logic von, input logic [5:0] lines, input logic [11:0] exp,
                     input string tag);
    step(1'b1, 1'b1, von, lines);
    for (int i = 0; i < int'(LL); i++) step(1'b1, 1'b1, 1'b0, 6'h0);
    check_eq(tag, 32'(rgb), 32'(exp));
  endtask

  task automatic pal_op(input logic we, input logic [2:0] a, input logic [11:0] d,
                        input logic cm);
    pal_wr_en   = we;
    pal_wr_addr = a;
    pal_wr_data = d;
    pal_commit  = cm;
    step(1'b1, 1'b1, 1'b0, 6'h0);
    pal_wr_en   = 1'b0;
    pal_commit  = 1'b0;
  endtask

  // Two-cycle vsync pulse; optional write/commit land on the detected boundary cycle.
  task automatic frame_boundary(input logic exp_done, input logic wr_b,
                                input logic [11:0] wr_d, input logic cm_b);
    for (int i = 0; i <= int'(LL) + 1; i++) begin
      if (i == int'(LL)) begin
        pal_wr_en   = wr_b;
        pal_wr_addr = 3'd0;
        pal_wr_data = wr_d;
        pal_commit  = cm_b;
      end
      step(1'b1, (i < 2) ? 1'b0 : 1'b1, 1'b0, 6'h0);
      pal_wr_en  = 1'b0;
      pal_commit = 1'b0;
      if (i == int'(LL) - 1) begin
        check_eq("tick_early", 32'(frame_tick), 32'(0));
        check_eq("vs_early", 32'(vsync_out), 32'(1));
        check_eq("pend_before", 32'(pal_pending), 32'(exp_done));
      end else if (i == int'(LL)) begin
        check_eq("tick", 32'(frame_tick), 32'(1));
        check_eq("vs_fall", 32'(vsync_out), 32'(0));
        check_eq("done", 32'(pal_done), 32'(exp_done));
        check_eq("pend_after", 32'(pal_pending), 32'(cm_b && !exp_done));
      end else if (i == int'(LL) + 1) begin
        check_eq("tick_once", 32'(frame_tick), 32'(0));
        check_eq("done_once", 32'(pal_done), 32'(0));
      end
    end
    frames++;
    for (int i = 0; i <= int'(LL); i++) step(1'b1, 1'b1, 1'b0, 6'h0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(LL); i++) line_pipe[i] = 6'h0;
    rst = 1'b0;
    {hsync_in, vsync_in, video_on_in} = 3'b110;
    {onLine6, onLine5, onLine4, onLine3, onLine2, onLine1} = 6'h0;
    pal_wr_en = 1'b0; pal_wr_addr = 3'd0; pal_wr_data = 12'h0; pal_commit = 1'b0;
    hl_en = 1'b0; hl_sel = 3'd7;
    #2;

    // Activity while held in reset must not reach the pins
    for (int i = 0; i < 4; i++) step(1'(i % 2), 1'b1, 1'b1, 6'b000100);
    check_eq("rst_rgb", 32'(rgb), 32'(0));
    check_eq("rst_hs", 32'(hsync_out), 32'(1));
    check_eq("rst_vs", 32'(vsync_out), 32'(1));
    check_eq("rst_pend", 32'(pal_pending), 32'(0));
    check_eq("rst_tick", 32'(frame_tick), 32'(0));
    check_eq("rst_done", 32'(pal_done), 32'(0));
    for (int i = 0; i <= int'(LL); i++) step(1'b1, 1'b1, 1'b0, 6'h0);
    rst = 1'b1;

    // Exact LINE_LAT+1 latency on onLine3 with reset palette
    step(1'b1, 1'b1, 1'b1, 6'b000100);
    for (int i = 0; i < int'(LL) - 1; i++) step(1'b1, 1'b1, 1'b0, 6'h0);
    check_eq("lat_early", 32'(rgb), 32'(0));
    step(1'b1, 1'b1, 1'b0, 6'h0);
    check_eq("lat_first", 32'(rgb), 32'h0FFF);
    step(1'b1, 1'b1, 1'b0, 6'h0);
    check_eq("lat_after", 32'(rgb), 32'(0));

    pix(1'b1, 6'b000000, BG, "bg");
    pix(1'b1, 6'b100000, 12'hFFF, "edge6_reset_pal");

    // hsync alignment
    step(1'b0, 1'b1, 1'b0, 6'h0);
    for (int i = 0; i < int'(LL) - 1; i++) step(1'b1, 1'b1, 1'b0, 6'h0);
    check_eq("hs_early", 32'(hsync_out), 32'(1));
    step(1'b1, 1'b1, 1'b0, 6'h0);
    check_eq("hs_edge", 32'(hsync_out), 32'(0));
    step(1'b1, 1'b1, 1'b0, 6'h0);
    check_eq("hs_back", 32'(hsync_out), 32'(1));

    // Priority: write+commit on same cycle includes that write
    pal_op(1'b1, 3'd1, 12'h0F0, 1'b0);
    pal_op(1'b1, 3'd4, 12'h00F, 1'b1);
    check_eq("prio_pend", 32'(pal_pending), 32'(1));
    pal_op(1'b1, 3'd6, 12'h111, 1'b0);
    pix(1'b1, 6'b010010, 12'hFFF, "prio_old");
    frame_boundary(1'b1, 1'b0, 12'h0, 1'b0);
    pix(1'b1, 6'b010010, 12'h0F0, "prio");
    pix(1'b0, 6'b010010, 12'h000, "prio_blank");
    pix(1'b1, 6'b010000, 12'h00F, "edge5");

    // Commit mid-frame: old colour until boundary
    pal_op(1'b1, 3'd0, 12'h123, 1'b0);
    pal_op(1'b0, 3'd0, 12'h0, 1'b1);
    check_eq("commit_pend", 32'(pal_pending), 32'(1));
    pix(1'b1, 6'b000001, 12'hFFF, "commit_old");
    frame_boundary(1'b1, 1'b0, 12'h0, 1'b0);
    pix(1'b1, 6'b000001, 12'h123, "commit_new");

    // Write on the boundary cycle lands in shadow only
    pal_op(1'b1, 3'd0, 12'h789, 1'b1);
    frame_boundary(1'b1, 1'b1, 12'h456, 1'b0);
    pix(1'b1, 6'b000001, 12'h789, "collide_frame");
    frame_boundary(1'b0, 1'b0, 12'h0, 1'b0);
    pix(1'b1, 6'b000001, 12'h789, "collide_hold");
    pal_op(1'b0, 3'd0, 12'h0, 1'b1);
    frame_boundary(1'b1, 1'b0, 12'h0, 1'b0);
    pix(1'b1, 6'b000001, 12'h456, "collide_late");

    // Commit on the boundary cycle waits one more frame
    pal_op(1'b1, 3'd2, 12'hABC, 1'b0);
    frame_boundary(1'b0, 1'b0, 12'h0, 1'b1);
    pix(1'b1, 6'b000100, 12'hFFF, "cob_wait");
    frame_boundary(1'b1, 1'b0, 12'h0, 1'b0);
    pix(1'b1, 6'b000100, 12'hABC, "cob_done");

    // Blink with BLINK_FRAMES=2: phase = (frames/2) odd
    hl_en  = 1'b1;
    hl_sel = 3'd0;
    for (int f = 0; f < 4; f++) begin
      pix(1'b1, 6'b000011, (((frames / 2) % 2) == 1) ? HL : 12'h456, "blink");
      frame_boundary(1'b0, 1'b0, 12'h0, 1'b0);
    end
    hl_sel = 3'd7;
    for (int f = 0; f < 4; f++) begin
      pix(1'b1, 6'b000001, 12'h456, "no_hl");
      frame_boundary(1'b0, 1'b0, 12'h0, 1'b0);
    end
    hl_sel = 3'd1;
    pix(1'b1, 6'b000011, 12'h456, "hl_not_winner");

    // Reset while a commit is pending discards it
    pal_op(1'b1, 3'd2, 12'h0DE, 1'b1);
    check_eq("mid_pend", 32'(pal_pending), 32'(1));
    rst = 1'b0;
    #1;
    check_eq("mid_rst_pend", 32'(pal_pending), 32'(0));
    check_eq("mid_rst_rgb", 32'(rgb), 32'(0));
    step(1'b1, 1'b1, 1'b0, 6'h0);
    step(1'b1, 1'b1, 1'b0, 6'h0);
    rst = 1'b1;
    hl_en = 1'b0;
    frames = 0;
    frame_boundary(1'b0, 1'b0, 12'h0, 1'b0);
    pix(1'b1, 6'b000100, 12'hFFF, "post_rst_pal");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_pixel_mixer.md
Name: line_pixel_mixer

Overview:
- Downstream of the six-edge line-check stage in the wireframe tetrahedron render path.
- Consumes the six onLine flags, which lag the scan counters by LINE_LAT cycles.
- Delays the VGA sync and blanking signals so they line up with those flags.
- Resolves edge priority, applies a per-edge colour palette and a blinking edge highlight, then drives registered RGB and sync pins.
- Palette updates are double-buffered and commit only at a frame boundary, so a frame never shows a mix of old and new colours.

Parameters:
- LINE_LAT, 2: cycles from h_cnt_Q/v_cnt_Q valid to onLine flags valid; sets the sync delay depth (legal range 1..8).
- BLINK_FRAMES, 30: frames per blink half-period for the highlighted edge (legal range 1..255).
- BG_COLOR, 12'h000: colour for visible pixels that are on no edge.
- HL_COLOR, 12'hF00: colour of the highlighted edge while blink phase is 1.
- SYNC_ACTIVE_LOW, 1: 1 means hsync/vsync are active low, both on input and on output.

Ports:
- CLK  in  1  pixel clock; single clock domain.
- rst  in  1  asynchronous, active-low reset.
- hsync_in  in  1  horizontal sync, aligned with h_cnt_Q/v_cnt_Q.
- vsync_in  in  1  vertical sync, aligned with the counters.
- video_on_in  in  1  visible-area flag, aligned with the counters.
- onLine1..onLine6  in  1 each  edge hits from the line-check stage; each lags the counters by LINE_LAT.
- pal_wr_en  in  1  shadow palette write strobe.
- pal_wr_addr  in  3  edge index 0..5; values 6 and 7 are ignored.
- pal_wr_data  in  12  RGB444 colour, {R,G,B}.
- pal_commit  in  1  one-cycle request to copy shadow to active at the next frame boundary.
- pal_pending  out  1  high from commit request until the copy completes.
- pal_done  out  1  one-cycle pulse on the cycle the copy takes effect.
- hl_en  in  1  highlight enable.
- hl_sel  in  3  edge index to highlight, 0..5; values above 5 mean no highlight.
- vga_r, vga_g, vga_b  out  4 each  registered colour outputs.
- hsync_out, vsync_out  out  1 each  registered sync outputs, delayed LINE_LAT+1.
- frame_tick  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset values (asynchronous):
  - vga_r/g/b = 0.
  - hsync_out/vsync_out at their inactive level.
  - frame_tick, pal_done, pal_pending = 0.
  - Delay-line stages hold inactive sync and video_on = 0.
  - Active and shadow palettes all 12'hFFF.
  - Frame counter = 0, blink phase = 0.
- Reset asserted mid-commit discards the pending request.
- Delay line: hsync_in, vsync_in and video_on_in pass through a LINE_LAT-stage shift register, giving hs_d, vs_d, von_d. These are aligned with onLine1..6.
- Pixel select, combinational on the aligned signals:
  - If von_d = 0: colour = 0.
  - Else pick the lowest-numbered asserted onLine(k); edge index e = k-1. colour = active_pal[e].
  - If hl_en = 1, hl_sel = e and blink phase = 1: colour = HL_COLOR instead.
  - If no flag is asserted: colour = BG_COLOR.
  - The colour, hs_d and vs_d are registered once. Total latency from the counter-aligned inputs to the pins is LINE_LAT+1 cycles, identical for colour and sync.
- Frame boundary: the cycle where vs_d goes from inactive to active, detected with a one-cycle history register.
  - frame_tick is registered, so it pulses one cycle after detection, coincident with the vsync_out edge.
- Blink counter:
  - Increments on each frame boundary.
  - At count BLINK_FRAMES-1 it wraps to 0 and the blink phase toggles.
  - The counter runs whether or not hl_en is set.
- Palette writes:
  - pal_wr_en with pal_wr_addr 0..5 writes the shadow entry on that edge.
  - Writes are always accepted, with no back-pressure.
- Commit:
  - pal_commit sets pal_pending on the next edge. A commit while already pending has no further effect.
  - On a frame boundary with pal_pending = 1: all six active entries load from shadow, pal_pending clears, and pal_done pulses on the following cycle.
  - The new colours apply from the first pixel evaluated after the boundary.
- Simultaneous events:
  - A write on the boundary cycle: the copy takes the pre-write shadow contents, and the write lands in shadow only.
  - A commit on the boundary cycle: it is not serviced on that boundary; it waits for the next frame.
  - A commit on the same cycle as a write: the write is included in the next copy.
- hl_sel or hl_en changes take effect on the next pixel, with no frame alignment.

Decomposition:
- Shared package holds:
  - NUM_EDGES = 6, COLOR_W = 12.
  - The RGB444 field slices.
  - Palette reset colour 12'hFFF.
  - The sync-polarity inactive-level function.
- One natural sub-module: sync_delay_line, a parameterised width-by-depth shift register with asynchronous active-low reset and a per-bit reset value. It is instantiated once for {hsync, vsync, video_on}.

Test Plan:
- Reset: hold rst = 0 mid-frame -> RGB = 0, hsync_out/vsync_out = 1, pal_pending = 0. Release rst, drive onLine3 with video_on -> RGB = 12'hFFF exactly LINE_LAT+1 cycles after the counters.
- Priority: assert onLine2 and onLine5 together with pal[1] = 12'h0F0 and pal[4] = 12'h00F committed -> RGB = 12'h0F0. Same pixel with video_on_in = 0 -> RGB = 0.
- Alignment: toggle hsync_in at a known counter value -> hsync_out toggles at exactly LINE_LAT+1 cycles; frame_tick pulses on the same cycle as the vsync_out falling edge.
- Commit: write pal[0] = 12'h123, pulse pal_commit mid-frame -> pal_pending = 1 and the old colour persists to the end of the frame. At the boundary, pal_done pulses and the next frame shows 12'h123.
- Boundary collision: write pal[0] = 12'h456 on the exact boundary cycle with a commit pending -> this frame shows the previously shadowed value, and 12'h456 appears only after another commit.
- Blink: BLINK_FRAMES = 2, hl_en = 1, hl_sel = 0, onLine1 on -> colour alternates palette, HL_COLOR every 2 frames. With hl_sel = 7 -> no highlight ever.
